// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Results are computed at the start edge, parked in temp registers, and committed after a fixed latency.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [2:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntBits   = $clog2(MaxCycles + 1);
    localparam int unsigned CntW      = (CntBits < 4) ? 4 : CntBits;

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       tmp_hi_q, tmp_hi_d;
    logic [31:0]       tmp_lo_q, tmp_lo_d;
    logic              commit_q, commit_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               sign_a, sign_b;
    logic [31:0]        abs_a, abs_b;
    logic [31:0]        sdiv_b, udiv_b;
    logic [31:0]        sq_mag, sr_mag, sq, sr, uq, ur;

    assign prod_s = $signed({{32{SrcA[31]}}, SrcA}) * $signed({{32{SrcB[31]}}, SrcB});
    assign prod_u = {32'd0, SrcA} * {32'd0, SrcB};

    // Signed division on magnitudes; 0x80000000 is a valid unsigned magnitude, so the
    // overflow case falls out as 0x80000000 / 1 negated back to 0x80000000.
    assign sign_a = SrcA[31];
    assign sign_b = SrcB[31];
    assign abs_a  = sign_a ? (32'd0 - SrcA) : SrcA;
    assign abs_b  = sign_b ? (32'd0 - SrcB) : SrcB;
    assign sdiv_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
    assign udiv_b = (SrcB == 32'd0) ? 32'd1 : SrcB;
    assign sq_mag = abs_a / sdiv_b;
    assign sr_mag = abs_a % sdiv_b;
    assign sq     = (sign_a ^ sign_b) ? (32'd0 - sq_mag) : sq_mag;
    assign sr     = sign_a ? (32'd0 - sr_mag) : sr_mag;
    assign uq     = SrcA / udiv_b;
    assign ur     = SrcA % udiv_b;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        commit_d = commit_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    case (MDUOp)
                        OpMult: begin
                            tmp_hi_d = prod_s[63:32];
                            tmp_lo_d = prod_s[31:0];
                            commit_d = 1'b1;
                            cnt_d    = CntW'(MULT_CYCLES);
                            state_d  = StRun;
                        end
                        OpMultu: begin
                            tmp_hi_d = prod_u[63:32];
                            tmp_lo_d = prod_u[31:0];
                            commit_d = 1'b1;
                            cnt_d    = CntW'(MULT_CYCLES);
                            state_d  = StRun;
                        end
                        OpDiv: begin
                            tmp_hi_d = sr;
                            tmp_lo_d = sq;
                            commit_d = (SrcB != 32'd0);
                            cnt_d    = CntW'(DIV_CYCLES);
                            state_d  = StRun;
                        end
                        OpDivu: begin
                            tmp_hi_d = ur;
                            tmp_lo_d = uq;
                            commit_d = (SrcB != 32'd0);
                            cnt_d    = CntW'(DIV_CYCLES);
                            state_d  = StRun;
                        end
                        OpMthi:  hi_d = SrcA;
                        OpMtlo:  lo_d = SrcA;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                // Start is ignored here, including on the completing edge.
                if (cnt_q <= CntW'(1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (commit_q) begin
                        hi_d = tmp_hi_q;
                        lo_d = tmp_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
            commit_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            commit_q <= commit_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign Busy = (state_q == StRun);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, is the number of busy cycles for mult and multu.
REQ-002 Parameter DIV_CYCLES, default 10, is the number of busy cycles for div and divu.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  is the reset: asynchronous, active-low.
REQ-005 Port SrcA  input  32  is operand A (rs value): multiplicand, dividend, or mthi/mtlo data.
REQ-006 Port SrcB  input  32  is operand B (rt value): multiplier or divisor.
REQ-007 Port MDUOp  input  3  is the operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-008 Port Start  input  1  is the operation-valid strobe, sampled each rising edge.
REQ-009 Port Busy  output  1  is high while a mult/div is in flight.
REQ-010 Port HI  output  32  is the registered HI value.
REQ-011 Port LO  output  32  is the registered LO value.

Function
REQ-012 The unit SHALL use two states: IDLE (Busy=0) and RUN (Busy=1), plus a down-counter of at least 4 bits.
REQ-013 In IDLE, Start=1 with MDUOp in {1,2,3,4} SHALL latch the computed result into internal temp registers, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN at that edge.
REQ-014 In RUN, the counter SHALL decrement each edge; on the edge where it reaches 0, HI/LO SHALL take the temp values and the state SHALL return to IDLE.
REQ-015 Latency: for Start sampled at edge T, Busy SHALL be 1 from after T until edge T+N; HI/LO change exactly at edge T+N, where N is MULT_CYCLES or DIV_CYCLES.
REQ-016 HI/LO SHALL hold their previous values throughout RUN, so in-flight reads return old values.
REQ-017 Start while Busy=1 SHALL be ignored entirely (no op, no restart, no HI/LO write), including on the completing edge.
REQ-018 In IDLE, Start=1 with mthi (or mtlo) SHALL write SrcA to HI (or LO) at that edge, with Busy staying 0.
REQ-019 Start=1 with MDUOp 0 or 7 SHALL have no effect.
REQ-020 mult SHALL form the signed 64-bit product and multu the unsigned product; HI = bits [63:32], LO = bits [31:0].
REQ-021 div/divu SHALL place the quotient in LO and the remainder in HI; signed div truncates toward zero, and the remainder takes the sign of the dividend.
REQ-022 Signed overflow (0x80000000 div 0xFFFFFFFF) SHALL give LO=0x80000000, HI=0x00000000.
REQ-023 A divisor of 0 (div or divu) SHALL still run DIV_CYCLES with Busy=1, then leave HI/LO unchanged.
REQ-024 Operands SHALL be captured only at the Start edge; SrcA/SrcB changes during RUN SHALL not affect the result.

Reset
REQ-025 reset=0 SHALL immediately, without waiting for clk, force HI=0, LO=0, Busy=0, state=IDLE, counter=0, and temp registers=0.
REQ-026 reset asserted mid-RUN SHALL abort the operation, and no HI/LO commit SHALL occur after release.
REQ-027 After reset deasserts, the first rising edge SHALL accept a Start normally.

Verification
REQ-028 mult with SrcA=0xFFFFFFFF, SrcB=0x00000002 -> Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-029 div with SrcA=0xFFFFFFF9 (-7), SrcB=0x00000002 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 -> LO=3, HI=1.
REQ-030 divu 5/0 preceded by mthi 0x11, mtlo 0x22 -> Busy high for 10 cycles, then HI=0x11, LO=0x22 unchanged.
REQ-031 mult 3*4 started, then Start+mtlo 0x55 at cycle 2 and Start+div at the completing edge -> both ignored; final HI=0, LO=12, Busy=0.
REQ-032 div started, reset pulsed low at cycle 4 (asynchronously, between edges) -> HI=LO=0 and Busy=0 immediately, and no later commit.
REQ-033 0x80000000 div 0xFFFFFFFF -> LO=0x80000000, HI=0; SrcA/SrcB toggled during RUN -> result unaffected.
